// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern sequencer.
package vga_pkg;

    localparam int H_ACT_DEF = 1024;
    localparam int V_ACT_DEF = 768;

    typedef enum logic [2:0] {
        MODE_WHITE   = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_GREY    = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_MOVBAR  = 3'd4
    } mode_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    typedef logic [0:0] state_t;
    localparam state_t S_WAIT_SYNC = 1'b0;
    localparam state_t S_RUN       = 1'b1;

    // Colour-bar order, left to right: W,Y,C,G,M,R,B,K.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational pattern generator: (mode, x, y, frame) -> 24-bit {R,G,B}.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACT     = H_ACT_DEF,
    parameter int NUM_MODES = 5
) (
    input  logic [2:0]  mode,
    input  logic [10:0] x,
    input  logic        y_tile,
    input  logic [7:0]  frame,
    output logic [23:0] rgb
);

    // Bar width H_ACT/8 is assumed to be a power of two.
    localparam int         BAR_SHIFT  = $clog2(H_ACT / 8);
    localparam logic [3:0] MODE_LIMIT = 4'(NUM_MODES);

    logic [10:0] bar;
    logic [9:0]  bar_rel;

    always_comb begin
        bar     = x >> BAR_SHIFT;
        bar_rel = x[9:0] - {frame, 2'b00};
        rgb     = RGB_BLACK;
        if ({1'b0, mode} < MODE_LIMIT) begin
            case (mode)
                MODE_WHITE:   rgb = RGB_WHITE;
                MODE_BARS:    rgb = (bar < 11'd8) ? bar_colour(bar[2:0]) : RGB_BLACK;
                MODE_GREY:    rgb = {3{x[9:2]}};
                MODE_CHECKER: rgb = (x[6] ^ y_tile) ? RGB_WHITE : RGB_BLACK;
                MODE_MOVBAR:  rgb = (bar_rel < 10'd32) ? RGB_RED : RGB_BLACK;
                default:      rgb = RGB_BLACK;
            endcase
        end
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer feeding the VGA timing block; tracks x/y and switches patterns on frame starts.
// Host handshake: a request transfers on any clock edge where MODE_REQ_VLD && MODE_REQ_RDY; RDY then stays low until the next frame start applies it.
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int H_ACT           = H_ACT_DEF,
    parameter int V_ACT           = V_ACT_DEF,
    parameter int NUM_MODES       = 5,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic        VGA_CLK,
    input  logic        VGA_RST_N,
    input  logic        VGA_VSYNC,
    input  logic        VGA_IF_RGBEN,
    input  logic        AUTO_EN,
    input  logic [2:0]  MODE_REQ,
    input  logic        MODE_REQ_VLD,
    output logic        MODE_REQ_RDY,
    output logic [23:0] VGA_BUF_RGB,
    output logic [2:0]  CUR_MODE,
    output logic [15:0] FRAME_CNT,
    output logic        FRAME_START,
    output logic        ERR_OVERRUN,
    output logic [0:0]  DBG_STATE
);

    localparam int            CW         = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [10:0]   H_LIM      = 11'(H_ACT);
    localparam logic [10:0]   V_LIM      = 11'(V_ACT);
    localparam logic [3:0]    MODE_LIMIT = 4'(NUM_MODES);
    localparam logic [2:0]    LAST_MODE  = 3'(NUM_MODES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(FRAMES_PER_MODE - 1);

    state_t        state;
    logic          vsync_q;
    logic          rgben_q;
    logic          frame_fall;
    logic          rgben_fall;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [CW-1:0] mode_cnt;
    logic [2:0]    pend_mode;
    logic [2:0]    next_auto_mode;
    logic [23:0]   pix;

    assign frame_fall     = vsync_q & ~VGA_VSYNC;
    assign rgben_fall     = rgben_q & ~VGA_IF_RGBEN;
    assign next_auto_mode = (CUR_MODE >= LAST_MODE) ? 3'd0 : CUR_MODE + 3'd1;
    assign DBG_STATE      = state;

    vga_pattern_gen #(
        .H_ACT     (H_ACT),
        .NUM_MODES (NUM_MODES)
    ) u_gen (
        .mode   (CUR_MODE),
        .x      (x),
        .y_tile (y[6]),
        .frame  (FRAME_CNT[7:0]),
        .rgb    (pix)
    );

    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            state        <= S_WAIT_SYNC;
            vsync_q      <= 1'b0;  // low so a VSYNC held low through reset is not taken as an edge
            rgben_q      <= 1'b0;
            x            <= '0;
            y            <= '0;
            mode_cnt     <= '0;
            pend_mode    <= '0;
            MODE_REQ_RDY <= 1'b1;
            VGA_BUF_RGB  <= '0;
            CUR_MODE     <= '0;
            FRAME_CNT    <= '0;
            FRAME_START  <= 1'b0;
            ERR_OVERRUN  <= 1'b0;
        end else begin
            vsync_q     <= VGA_VSYNC;
            rgben_q     <= VGA_IF_RGBEN;
            FRAME_START <= frame_fall;

            if (MODE_REQ_VLD && MODE_REQ_RDY) begin
                pend_mode    <= ({1'b0, MODE_REQ} >= MODE_LIMIT) ? 3'd0 : MODE_REQ;
                MODE_REQ_RDY <= 1'b0;
            end

            if (frame_fall) begin
                state     <= S_RUN;
                x         <= '0;
                y         <= '0;
                FRAME_CNT <= FRAME_CNT + 16'd1;
                // A pending host request outranks auto sequencing.
                if (!MODE_REQ_RDY) begin
                    CUR_MODE     <= pend_mode;
                    MODE_REQ_RDY <= 1'b1;
                    mode_cnt     <= '0;
                end else if (AUTO_EN) begin
                    if (mode_cnt == CNT_LAST) begin
                        CUR_MODE <= next_auto_mode;
                        mode_cnt <= '0;
                    end else begin
                        mode_cnt <= mode_cnt + CW'(1);
                    end
                end
            end else if (state == S_RUN) begin
                if (VGA_IF_RGBEN) begin
                    if (x >= H_LIM) ERR_OVERRUN <= 1'b1;
                    if (x != 11'h7FF) x <= x + 11'd1;
                end else if (rgben_fall) begin
                    x <= '0;
                    if (y >= V_LIM) ERR_OVERRUN <= 1'b1;
                    if (y != 11'h7FF) y <= y + 11'd1;
                end
            end

            VGA_BUF_RGB <= (state == S_RUN && VGA_IF_RGBEN) ? pix : 24'h000000;
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer: vector table for pattern pixels plus hand-written frame sequences.
module tb_vga_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_vsync;
    logic        vga_if_rgben;
    logic        auto_en;
    logic [2:0]  mode_req;
    logic        mode_req_vld;
    logic        mode_req_rdy;
    logic [23:0] vga_buf_rgb;
    logic [2:0]  cur_mode;
    logic [15:0] frame_cnt;
    logic        frame_start;
    logic        err_overrun;
    logic [0:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fs_seen  = 0;
    logic [15:0] exp_fc   = 16'd0;
    logic [23:0] cap [0:2047];
    logic [23:0] exp_q [$];

    typedef struct {
        logic [2:0]  req;
        int          y;
        int          x;
        logic [2:0]  exp_mode;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs [19];
    int   auto_exp [11];

    vga_pattern_sequencer #(
        .H_ACT           (1024),
        .V_ACT           (768),
        .NUM_MODES       (5),
        .FRAMES_PER_MODE (2)
    ) dut (
        .VGA_CLK      (clk),
        .VGA_RST_N    (rst_n),
        .VGA_VSYNC    (vga_vsync),
        .VGA_IF_RGBEN (vga_if_rgben),
        .AUTO_EN      (auto_en),
        .MODE_REQ     (mode_req),
        .MODE_REQ_VLD (mode_req_vld),
        .MODE_REQ_RDY (mode_req_rdy),
        .VGA_BUF_RGB  (vga_buf_rgb),
        .CUR_MODE     (cur_mode),
        .FRAME_CNT    (frame_cnt),
        .FRAME_START  (frame_start),
        .ERR_OVERRUN  (err_overrun),
        .DBG_STATE    (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_start === 1'b1) fs_seen++;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_const(input int n, input logic [23:0] val);
        for (int i = 0; i < n; i++) exp_q.push_back(val);
    endtask

    task automatic check_line(input string name, input int n);
        logic [23:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s[x=%0d]", name, i), {8'h00, cap[i]}, {8'h00, e});
        end
    endtask

    // Driver tasks; each starts and ends at a falling clock edge
    task automatic run_line(input int n);
        for (int i = 0; i < n; i++) begin
            vga_if_rgben = 1'b1;
            @(posedge clk); @(negedge clk);
            cap[i] = vga_buf_rgb;
        end
        vga_if_rgben = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_frame_start(input logic [2:0] em);
        vga_vsync = 1'b0;
        @(posedge clk); @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        check("frame_start_hi", {31'd0, frame_start}, 32'd1);
        check("cur_mode", {29'd0, cur_mode}, {29'd0, em});
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
        check("state_run", {31'd0, dbg_state}, 32'd1);
        check("rdy_after_fs", {31'd0, mode_req_rdy}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("frame_start_lo", {31'd0, frame_start}, 32'd0);
        vga_vsync = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic req_mode(input logic [2:0] m);
        int waited = 0;
        mode_req     = m;
        mode_req_vld = 1'b1;
        while (mode_req_rdy !== 1'b1 && waited < 20) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        check("req_rdy_wait", {31'd0, mode_req_rdy}, 32'd1);
        @(posedge clk); @(negedge clk);
        mode_req_vld = 1'b0;
        check("rdy_drop", {31'd0, mode_req_rdy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, {8'h00, vga_buf_rgb}, 32'd0);
        check({tag, "_mode"}, {29'd0, cur_mode}, 32'd0);
        check({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
        check({tag, "_fstart"}, {31'd0, frame_start}, 32'd0);
        check({tag, "_err"}, {31'd0, err_overrun}, 32'd0);
        check({tag, "_rdy"}, {31'd0, mode_req_rdy}, 32'd1);
        check({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        // Vector table: {request, line y, pixel x, expected mode, expected rgb}
        vecs[0]  = '{3'd1, 0, 0,    3'd1, 24'hFFFFFF};
        vecs[1]  = '{3'd1, 0, 127,  3'd1, 24'hFFFFFF};
        vecs[2]  = '{3'd1, 0, 128,  3'd1, 24'hFFFF00};
        vecs[3]  = '{3'd1, 0, 300,  3'd1, 24'h00FFFF};
        vecs[4]  = '{3'd1, 0, 400,  3'd1, 24'h00FF00};
        vecs[5]  = '{3'd1, 0, 520,  3'd1, 24'hFF00FF};
        vecs[6]  = '{3'd1, 0, 700,  3'd1, 24'hFF0000};
        vecs[7]  = '{3'd1, 0, 800,  3'd1, 24'h0000FF};
        vecs[8]  = '{3'd1, 0, 1000, 3'd1, 24'h000000};
        vecs[9]  = '{3'd1, 0, 1023, 3'd1, 24'h000000};
        vecs[10] = '{3'd2, 0, 4,    3'd2, 24'h010101};
        vecs[11] = '{3'd2, 0, 1023, 3'd2, 24'hFFFFFF};
        vecs[12] = '{3'd2, 3, 515,  3'd2, 24'h808080};
        vecs[13] = '{3'd3, 64, 64,  3'd3, 24'h000000};
        vecs[14] = '{3'd3, 64, 0,   3'd3, 24'hFFFFFF};
        vecs[15] = '{3'd3, 70, 130, 3'd3, 24'hFFFFFF};
        vecs[16] = '{3'd6, 0, 10,   3'd0, 24'hFFFFFF};
        vecs[17] = '{3'd7, 2, 5,    3'd0, 24'hFFFFFF};
        vecs[18] = '{3'd0, 0, 127,  3'd0, 24'hFFFFFF};
        auto_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};

        rst_n        = 1'b0;
        vga_vsync    = 1'b1;
        vga_if_rgben = 1'b0;
        auto_en      = 1'b0;
        mode_req     = 3'd0;
        mode_req_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        // No VSYNC edge yet: strobes must produce black and nothing counts
        for (int i = 0; i < 50; i++) begin
            run_line(1);
            check("wait_sync_rgb", {8'h00, cap[0]}, 32'd0);
        end
        check("wait_sync_fcnt", {16'd0, frame_cnt}, 32'd0);
        check("wait_sync_rdy", {31'd0, mode_req_rdy}, 32'd1);
        check("wait_sync_state", {31'd0, dbg_state}, 32'd0);

        // First frame, mode 0; host request lands mid-frame
        do_frame_start(3'd0);
        run_line(1024);
        push_const(1024, 24'hFFFFFF);
        check_line("f1_line0", 1024);
        for (int l = 1; l < 384; l++) begin
            run_line(1);
            check("f1_white", {8'h00, cap[0]}, 32'h00FFFFFF);
        end
        req_mode(3'd3);
        check("f1_mode_held", {29'd0, cur_mode}, 32'd0);
        for (int l = 384; l < 767; l++) begin
            run_line(1);
            check("f1_white", {8'h00, cap[0]}, 32'h00FFFFFF);
        end
        run_line(1024);
        push_const(1024, 24'hFFFFFF);
        check_line("f1_line767", 1024);
        check("f1_no_err", {31'd0, err_overrun}, 32'd0);
        check("f1_fs_once", fs_seen, 32'd1);
        check("f1_rdy_low", {31'd0, mode_req_rdy}, 32'd0);

        // Checkerboard frame
        do_frame_start(3'd3);
        run_line(65);
        check("chk_0_0", {8'h00, cap[0]}, 32'd0);
        check("chk_64_0", {8'h00, cap[64]}, 32'h00FFFFFF);
        repeat (63) run_line(1);
        run_line(65);
        check("chk_64_64", {8'h00, cap[64]}, 32'd0);
        check("chk_0_64", {8'h00, cap[0]}, 32'h00FFFFFF);

        // Moving bar at FRAME_CNT=8: red for x in 32..63
        while (exp_fc != 16'd7) do_frame_start(3'd3);
        req_mode(3'd4);
        do_frame_start(3'd4);
        run_line(100);
        for (int i = 0; i < 100; i++) exp_q.push_back((i >= 32 && i < 64) ? 24'hFF0000 : 24'h000000);
        check_line("movbar", 100);

        // Pattern vector table
        foreach (vecs[i]) begin
            req_mode(vecs[i].req);
            do_frame_start(vecs[i].exp_mode);
            repeat (vecs[i].y) run_line(1);
            run_line(vecs[i].x + 1);
            check($sformatf("vec%0d", i), {8'h00, cap[vecs[i].x]}, {8'h00, vecs[i].exp_rgb});
        end

        // Auto sequencing, two frames per mode
        auto_en = 1'b1;
        req_mode(3'd0);
        foreach (auto_exp[i]) do_frame_start(3'(auto_exp[i]));
        do_frame_start(3'd0);
        req_mode(3'd3);
        do_frame_start(3'd3);
        do_frame_start(3'd3);
        do_frame_start(3'd4);
        auto_en = 1'b0;
        do_frame_start(3'd4);
        do_frame_start(3'd4);
        auto_en = 1'b1;
        do_frame_start(3'd4);
        do_frame_start(3'd0);
        auto_en = 1'b0;

        // Horizontal overrun: 1024 strobes fine, 1025 sets sticky error
        do_frame_start(3'd0);
        run_line(1024);
        check("ovr_h_1024", {31'd0, err_overrun}, 32'd0);
        run_line(1025);
        check("ovr_h_1025", {31'd0, err_overrun}, 32'd1);
        do_frame_start(3'd0);
        check("ovr_sticky", {31'd0, err_overrun}, 32'd1);

        // Asynchronous reset in the middle of a line
        vga_if_rgben = 1'b1;
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        vga_if_rgben = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n  = 1'b1;
        exp_fc = 16'd0;
        for (int i = 0; i < 20; i++) begin
            run_line(1);
            check("post_reset_black", {8'h00, cap[0]}, 32'd0);
        end
        check("post_reset_state", {31'd0, dbg_state}, 32'd0);
        do_frame_start(3'd0);
        run_line(4);
        push_const(4, 24'hFFFFFF);
        check_line("resync_white", 4);

        // Vertical overrun: 768 lines fine, the 769th sets the error
        repeat (767) run_line(1);
        check("ovr_v_768", {31'd0, err_overrun}, 32'd0);
        run_line(1);
        check("ovr_v_769", {31'd0, err_overrun}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
